exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle control sequencer for the 13-bit RISC processor. It fetches instructions, reads the register file, drives the combinational ALU's opcode and operands, and consumes its result and branch flag. It also runs data-memory handshakes and writes results back, one instruction at a time. It is the initiator for the ALU and sits between instruction memory, register file, ALU and data memory.

## Interface
Parameters
- DW, 13, datapath / instruction width
- PCW, 8, program-counter and data-address width

Ports
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_run  in  1  start/continue execution; sampled only at instruction boundaries
- o_imem_addr  out  PCW  instruction address (= PC)
- i_imem_data  in  DW  instruction word, valid one cycle after address
- o_rf_ra, o_rf_rb  out  3  register-file read addresses (combinational read)
- i_rf_da, i_rf_db  in  DW  register-file read data
- o_rf_we  out  1  register write strobe
- o_rf_wa  out  3  write address
- o_rf_wd  out  DW  write data
- o_alu_opcode  out  4  ALU opcode
- o_alu_dataA, o_alu_dataB  out  DW  ALU operands
- i_alu_result  in  DW  ALU result
- i_alu_checkbranch  in  1  ALU branch-condition flag
- o_dmem_addr  out  PCW  data address
- o_dmem_wdata  out  DW  store data
- o_dmem_re, o_dmem_we  out  1  read / write request
- i_dmem_ready  in  1  memory completes current request
- o_pc  out  PCW  current PC
- o_state  out  3  FSM state encoding
- o_retire  out  1  one-cycle pulse on the final cycle of every instruction

## Operation
- Instruction fields: opcode [12:9], f1 [8:6], f2 [5:3], f3 [2:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR, 8 J, 9 BEQ, A BGT, B BLT, C BNE, D SW, E LD, F LSL.
- ALU ops (1-7, F): R[f1] <= R[f2] op R[f3].
- J: PC <= ir[7:0].
- Branch (9-C): compare R[f1] against R[f2]. If taken, PC <= PC+1+sext(f3); otherwise PC <= PC+1.
- LD: R[f1] <= M[R[f2]+zext(f3)].
- SW: M[R[f2]+zext(f3)] <= R[f1].
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Encodings 6-7 go to IDLE.
- IDLE: if i_run, go to FETCH; otherwise stay.
- FETCH: o_imem_addr=PC. Go to DECODE.
- DECODE: o_rf_ra/rb are taken combinationally from i_imem_data.
  - For ALU ops: ra=f2, rb=f3.
  - For branch, LD and SW: ra=f1, rb=f2.
  - Latch IR<=i_imem_data, A<=i_rf_da, B<=i_rf_db. Go to EXEC.
- EXEC: o_alu_opcode and operands are driven from IR/A/B.
  - ALU op: opcode=IR opcode, dataA=A, dataB=B. Latch R<=i_alu_result. Go to WB.
  - Branch: opcode=IR opcode, dataA=A, dataB=B. Taken = i_alu_checkbranch, sampled only here. The ALU must drive the flag 0 when the condition is false. Update PC and end the instruction.
  - LD/SW: opcode=ADD (0001). Load/store address operand is B (R[f2]); store data is A (R[f1]). Address latched as i_alu_result[PCW-1:0]. Go to MEM.
  - NOP, J: update PC and end the instruction. ALU opcode 0.
- MEM: o_dmem_addr, o_dmem_wdata and re (LD) or we (SW) are held stable until i_dmem_ready.
  - On ready with SW: PC+1, end the instruction.
  - On ready with LD: R<=i_dmem_rdata, go to WB.
- WB: o_rf_we=1 for exactly one cycle, wa=IR f1, wd=R. PC+1, end the instruction.
- End of instruction: assert o_retire. Next state is FETCH if i_run, else IDLE.
- Outside EXEC, o_alu_opcode=0 and the ALU operands are 0.
- Arithmetic:
  - PC arithmetic is modulo 2^PCW; 0xFF+1 wraps to 0x00.
  - Branch target wraps modulo 256.
  - Address sum is truncated to PCW bits.
  - ALU results are taken unmodified. Divide-by-zero and overflow are the ALU's concern.

## Timing
- Reset values: state IDLE, PC=0, IR/A/B/R=0. All outputs are 0: strobes, o_retire, o_alu_opcode, o_rf_we, o_dmem_re/we.
- Reset is honoured in any state, including mid-MEM. The request deasserts the cycle after the reset edge, and no register write or PC update occurs.
- Latency per instruction, counted from the FETCH cycle:
  - NOP / J / branch: 3 cycles.
  - ALU op: 4 cycles.
  - SW: 3 + N cycles; LD: 4 + N cycles. N ≥ 1 is the number of MEM cycles up to and including the ready cycle.
- i_dmem_ready outside MEM is ignored. i_run deasserting mid-instruction takes effect only at the boundary.
- o_rf_we never asserts together with o_dmem_we.

## Test plan
- Reset, then i_run=1 with mem[0]=0x0253 (ADD R1,R2,R3), R2=5, R3=7 -> exactly one write of R1=12 in cycle 4, o_retire pulses, PC=1.
- BEQ R1,R2,+2 with R1=R2=9 -> PC 4->7; BNE with equal operands -> PC 4->5; each in 3 cycles with no register write.
- J 0x00 at PC=0xFF, plus a NOP at 0xFF -> PC 0x00 (wrap).
- LD R4,[R2+3] with R2=0x10, ready held low for 3 cycles -> o_dmem_addr=0x13 and re held for 4 cycles; R4 written with rdata; 8 cycles total.
- SW R1,[R2+1] with i_rst asserted on the second MEM cycle -> we drops next cycle, state IDLE, PC=0, no retire.
- i_run dropped during EXEC of an ALU op -> WB completes, then IDLE; PC advanced by 1.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the 13-bit RISC core: fetch, register read,
// ALU drive, data-memory handshake and write-back, one instruction at a time.
module exec_sequencer #(
  parameter int DW  = 13,
  parameter int PCW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_run,
  output logic [PCW-1:0] o_imem_addr,
  input  logic [DW-1:0]  i_imem_data,
  output logic [2:0]     o_rf_ra,
  output logic [2:0]     o_rf_rb,
  input  logic [DW-1:0]  i_rf_da,
  input  logic [DW-1:0]  i_rf_db,
  output logic           o_rf_we,
  output logic [2:0]     o_rf_wa,
  output logic [DW-1:0]  o_rf_wd,
  output logic [3:0]     o_alu_opcode,
  output logic [DW-1:0]  o_alu_dataA,
  output logic [DW-1:0]  o_alu_dataB,
  input  logic [DW-1:0]  i_alu_result,
  input  logic           i_alu_checkbranch,
  output logic [PCW-1:0] o_dmem_addr,
  output logic [DW-1:0]  o_dmem_wdata,
  input  logic [DW-1:0]  i_dmem_rdata,
  output logic           o_dmem_re,
  output logic           o_dmem_we,
  input  logic           i_dmem_ready,
  output logic [PCW-1:0] o_pc,
  output logic [2:0]     o_state,
  output logic           o_retire
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_J   = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hD;
  localparam logic [3:0] OP_LD  = 4'hE;

  function automatic logic is_alu_op(input logic [3:0] op);
    return ((op != 4'h0) && (op < 4'h8)) || (op == 4'hF);
  endfunction

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hC);
  endfunction

  state_t         state;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] addr;
  logic [DW-1:0]  ir;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic [DW-1:0]  r;

  logic [3:0]     ir_op;
  logic [3:0]     dec_op;
  logic           is_mem;
  logic           end_instr;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] br_target;

  assign ir_op     = ir[12:9];
  assign dec_op    = i_imem_data[12:9];
  assign is_mem    = (ir_op == OP_LD) || (ir_op == OP_SW);
  assign pc_inc    = pc + 1'b1;
  assign br_target = pc_inc + {{(PCW-3){ir[2]}}, ir[2:0]};

  // Instruction ends in EXEC for NOP/J/branch, on the SW ready cycle, or in WB.
  assign end_instr = ((state == EXEC) && !is_alu_op(ir_op) && !is_mem) ||
                     ((state == MEM) && i_dmem_ready && (ir_op == OP_SW)) ||
                     (state == WB);

  assign o_imem_addr = pc;
  assign o_pc        = pc;
  assign o_state     = state;
  assign o_retire    = end_instr;

  assign o_rf_we = (state == WB);
  assign o_rf_wa = ir[8:6];
  assign o_rf_wd = r;

  // Memory handshake: re/we, address and store data stay stable from the first
  // MEM cycle until the cycle in which i_dmem_ready is high; ready is ignored
  // in every other state.
  assign o_dmem_re    = (state == MEM) && (ir_op == OP_LD);
  assign o_dmem_we    = (state == MEM) && (ir_op == OP_SW);
  assign o_dmem_addr  = addr;
  assign o_dmem_wdata = a;

  always_comb begin
    o_rf_ra = 3'd0;
    o_rf_rb = 3'd0;
    if (state == DECODE) begin
      if (is_alu_op(dec_op)) begin
        o_rf_ra = i_imem_data[5:3];
        o_rf_rb = i_imem_data[2:0];
      end else begin
        o_rf_ra = i_imem_data[8:6];
        o_rf_rb = i_imem_data[5:3];
      end
    end
  end

  always_comb begin
    o_alu_opcode = 4'h0;
    o_alu_dataA  = '0;
    o_alu_dataB  = '0;
    if (state == EXEC) begin
      if (is_alu_op(ir_op) || is_branch_op(ir_op)) begin
        o_alu_opcode = ir_op;
        o_alu_dataA  = a;
        o_alu_dataB  = b;
      end else if (is_mem) begin
        o_alu_opcode = OP_ADD;
        o_alu_dataA  = b;
        o_alu_dataB  = {{(DW-3){1'b0}}, ir[2:0]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      pc    <= '0;
      addr  <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
    end else begin
      case (state)
        IDLE:   if (i_run) state <= FETCH;
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= i_imem_data;
          a     <= i_rf_da;
          b     <= i_rf_db;
          state <= EXEC;
        end
        EXEC: begin
          if (is_alu_op(ir_op)) begin
            r     <= i_alu_result;
            state <= WB;
          end else if (is_mem) begin
            addr  <= i_alu_result[PCW-1:0];
            state <= MEM;
          end else begin
            if (ir_op == OP_J)
              pc <= ir[PCW-1:0];
            else if (is_branch_op(ir_op) && i_alu_checkbranch)
              pc <= br_target;
            else
              pc <= pc_inc;
            state <= i_run ? FETCH : IDLE;
          end
        end
        MEM: begin
          if (i_dmem_ready) begin
            if (ir_op == OP_SW) begin
              pc    <= pc_inc;
              state <= i_run ? FETCH : IDLE;
            end else begin
              r     <= i_dmem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          pc    <= pc_inc;
          state <= i_run ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: behavioural imem/RF/ALU/dmem around the DUT and an
// instruction-level model checked against the DUT outputs every cycle.
module tb_exec_sequencer;
  localparam int DW  = 13;
  localparam int PCW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic [PCW-1:0] imem_addr, dmem_addr, pc;
  logic [DW-1:0]  imem_data, rf_da, rf_db, rf_wd, alu_a, alu_b, alu_result;
  logic [DW-1:0]  dmem_wdata, dmem_rdata;
  logic [2:0]     rf_ra, rf_rb, rf_wa, state;
  logic [3:0]     alu_op;
  logic           rf_we, alu_br, dmem_re, dmem_we, dmem_ready, retire;

  exec_sequencer #(.DW(DW), .PCW(PCW)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_rf_ra(rf_ra), .o_rf_rb(rf_rb), .i_rf_da(rf_da), .i_rf_db(rf_db),
    .o_rf_we(rf_we), .o_rf_wa(rf_wa), .o_rf_wd(rf_wd),
    .o_alu_opcode(alu_op), .o_alu_dataA(alu_a), .o_alu_dataB(alu_b),
    .i_alu_result(alu_result), .i_alu_checkbranch(alu_br),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata),
    .o_dmem_re(dmem_re), .o_dmem_we(dmem_we), .i_dmem_ready(dmem_ready),
    .o_pc(pc), .o_state(state), .o_retire(retire)
  );

  // ---------------- environment ----------------
  logic [DW-1:0] imem [256];
  logic [DW-1:0] env_rf [8];
  logic [DW-1:0] env_dmem [256];
  int dmem_wait = 0;
  int mem_cnt = 0;

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (op)
      4'h1: return x + y;
      4'h2: return x - y;
      4'h3: return x * y;
      4'h4: return (y != 0) ? x / y : '0;
      4'h5: return x & y;
      4'h6: return x | y;
      4'h7: return x ^ y;
      4'hF: return x << y[3:0];
      default: return x - y;
    endcase
  endfunction

  function automatic logic br_fn(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (op)
      4'h9: return x == y;
      4'hA: return x > y;
      4'hB: return x < y;
      4'hC: return x != y;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) imem_data <= imem[imem_addr];
  assign rf_da      = env_rf[rf_ra];
  assign rf_db      = env_rf[rf_rb];
  always @(posedge clk) if (rf_we) env_rf[rf_wa] <= rf_wd;
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_br     = br_fn(alu_op, alu_a, alu_b);
  assign dmem_ready = (dmem_re || dmem_we) && (mem_cnt == dmem_wait);
  assign dmem_rdata = env_dmem[dmem_addr];

  always @(posedge clk) begin
    if (rst || !(dmem_re || dmem_we) || dmem_ready) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
    if (!rst && dmem_we && dmem_ready) env_dmem[dmem_addr] <= dmem_wdata;
  end

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0]  m_rf [8];
  logic [DW-1:0]  m_dmem [256];
  logic [PCW-1:0] m_pc = '0;
  logic [15:0]    exp_q [$];
  logic           active = 1'b0;
  int             cyc = 0;
  int             e_lat;
  logic           e_wb, e_mem, e_ld;
  logic [3:0]     e_op;
  logic [2:0]     e_f1, e_f2, e_f3;
  logic [PCW-1:0] e_pc, e_addr;
  logic [DW-1:0]  e_wd, e_sd;

  task automatic model_decode();
    logic [DW-1:0] ins;
    ins    = imem[m_pc];
    e_op   = ins[12:9];
    e_f1   = ins[8:6];
    e_f2   = ins[5:3];
    e_f3   = ins[2:0];
    e_lat  = 3;
    e_wb   = 1'b0;
    e_mem  = 1'b0;
    e_ld   = 1'b0;
    e_pc   = m_pc + 8'd1;
    e_addr = m_rf[e_f2][PCW-1:0] + {5'd0, e_f3};
    e_sd   = m_rf[e_f1];
    e_wd   = '0;
    if ((e_op >= 4'h1 && e_op <= 4'h7) || e_op == 4'hF) begin
      e_lat = 4;
      e_wb  = 1'b1;
      e_wd  = alu_fn(e_op, m_rf[e_f2], m_rf[e_f3]);
    end else if (e_op == 4'h8) begin
      e_pc = ins[7:0];
    end else if (e_op >= 4'h9 && e_op <= 4'hC) begin
      if (br_fn(e_op, m_rf[e_f1], m_rf[e_f2])) e_pc = m_pc + 8'd1 + {{5{e_f3[2]}}, e_f3};
    end else if (e_op == 4'hD) begin
      e_mem = 1'b1;
      e_lat = 3 + dmem_wait + 1;
    end else if (e_op == 4'hE) begin
      e_mem = 1'b1;
      e_ld  = 1'b1;
      e_wb  = 1'b1;
      e_lat = 4 + dmem_wait + 1;
      e_wd  = m_dmem[e_addr];
    end
    if (e_wb) exp_q.push_back({e_f1, e_wd});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic in_mem;
      logic [15:0] wr;
      if (active) begin
        if (cyc == 0) model_decode();
        in_mem = e_mem && (cyc >= 3) && (cyc < 3 + dmem_wait + 1);
        chk("retire", retire, cyc == e_lat - 1);
        chk("rf_we", rf_we, e_wb && (cyc == e_lat - 1));
        if (rf_we) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rf_write: got unexpected write R%0d=0x%0h, expected none", rf_wa, rf_wd);
          end else begin
            wr = exp_q.pop_front();
            n_cmp--;
            chk("rf_write", {rf_wa, rf_wd}, wr);
          end
        end
        chk("dmem_re", dmem_re, in_mem && e_ld);
        chk("dmem_we", dmem_we, in_mem && !e_ld);
        if (in_mem) chk("dmem_addr", dmem_addr, e_addr);
        if (in_mem && !e_ld) chk("dmem_wdata", dmem_wdata, e_sd);
        if (cyc == 1 && e_op != 4'h0 && e_op != 4'h8) begin
          if ((e_op >= 4'h1 && e_op <= 4'h7) || e_op == 4'hF) chk("rf_rd_addr", {rf_ra, rf_rb}, {e_f2, e_f3});
          else chk("rf_rd_addr", {rf_ra, rf_rb}, {e_f1, e_f2});
        end
        if (cyc == 2) begin
          if ((e_op >= 4'h1 && e_op <= 4'h7) || e_op == 4'hF)
            chk("alu_drive", {alu_op, alu_a, alu_b}, {e_op, m_rf[e_f2], m_rf[e_f3]});
          else if (e_op >= 4'h9 && e_op <= 4'hC)
            chk("alu_drive", {alu_op, alu_a, alu_b}, {e_op, m_rf[e_f1], m_rf[e_f2]});
          else if (e_mem)
            chk("alu_opcode", alu_op, 4'h1);
          else
            chk("alu_drive", {alu_op, alu_a, alu_b}, 30'd0);
        end else begin
          chk("alu_idle", {alu_op, alu_a, alu_b}, 30'd0);
        end
      end else begin
        chk("idle_state", state, 3'd0);
        chk("idle_strobes", {retire, rf_we, dmem_re, dmem_we}, 4'd0);
        chk("idle_alu", {alu_op, alu_a, alu_b}, 30'd0);
      end
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("we_excl", rf_we && dmem_we, 1'b0);

      if (rst) begin
        active = 1'b0;
        cyc    = 0;
        m_pc   = '0;
        exp_q.delete();
      end else if (active && cyc == e_lat - 1) begin
        if (e_wb) m_rf[e_f1] = e_wd;
        if (e_mem && !e_ld) m_dmem[e_addr] = e_sd;
        m_pc   = e_pc;
        active = run;
        cyc    = 0;
      end else if (active) begin
        cyc++;
      end else begin
        active = run;
        cyc    = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_reg(input int i, input logic [DW-1:0] v);
    env_rf[i] = v;
    m_rf[i]   = v;
  endtask

  task automatic set_mem(input int i, input logic [DW-1:0] v);
    env_dmem[i] = v;
    m_dmem[i]   = v;
  endtask

  task automatic wait_retire(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!retire && k < budget);
    n_cmp++;
    if (!retire) begin
      n_fail++;
      $display("FAIL retire_timeout: got no retire in %0d cycles, expected one", budget);
    end
  endtask

  // Runs one instruction from IDLE, dropping i_run while it is in EXEC.
  task automatic run_one();
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    run = 1'b0;
    wait_retire(20);
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      set_mem(i, '0);
    end
    for (int i = 0; i < 8; i++) set_reg(i, '0);

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_state", state, 3'd0);
    chk("reset_pc", pc, 8'h00);
    chk("reset_retire", retire, 1'b0);
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_dmem_req", {dmem_re, dmem_we}, 2'b00);
    chk("reset_alu_opcode", alu_op, 4'h0);

    // ADD R1,R2,R3
    set_reg(2, 13'd5);
    set_reg(3, 13'd7);
    imem[8'h00] = 13'h0253;
    run_one();
    chk("add_r1", env_rf[1], 13'd12);
    chk("add_pc", pc, 8'h01);

    // J 0x04, then BEQ taken / BNE not taken
    imem[8'h01] = 13'h1004;
    run_one();
    chk("j_pc", pc, 8'h04);
    set_reg(1, 13'd9);
    set_reg(2, 13'd9);
    imem[8'h04] = 13'h1252;
    imem[8'h07] = 13'h1004;
    run_one();
    chk("beq_pc", pc, 8'h07);
    run_one();
    imem[8'h04] = 13'h1852;
    run_one();
    chk("bne_pc", pc, 8'h05);

    // SUB R5,R3,R1 wraps negative
    imem[8'h05] = 13'h0559;
    run_one();
    chk("sub_r5", env_rf[5], 13'h1FFE);

    // J 0xFF then NOP at 0xFF wraps PC
    imem[8'h06] = 13'h10FF;
    run_one();
    chk("j_ff_pc", pc, 8'hFF);
    imem[8'hFF] = 13'h0000;
    run_one();
    chk("nop_wrap_pc", pc, 8'h00);

    // LD R4,[R2+3] with three not-ready cycles
    set_reg(2, 13'h010);
    set_mem(8'h13, 13'h0ABC);
    imem[8'h00] = 13'h1D13;
    dmem_wait = 3;
    run_one();
    chk("ld_r4", env_rf[4], 13'h0ABC);
    chk("ld_pc", pc, 8'h01);

    // SW R1,[R2+1] then read it back
    dmem_wait = 0;
    imem[8'h01] = 13'h1A51;
    run_one();
    chk("sw_mem", env_dmem[8'h11], 13'd9);
    dmem_wait = 1;
    imem[8'h02] = 13'h1D91;
    run_one();
    chk("ld_back_r6", env_rf[6], 13'd9);
    chk("ld_back_pc", pc, 8'h03);

    // SW interrupted by reset on its second MEM cycle
    set_reg(1, 13'h155);
    dmem_wait = 5;
    imem[8'h03] = 13'h1A51;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!dmem_we && k < 10);
      chk("sw_we_seen", dmem_we, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mem_state", state, 3'd0);
    chk("rst_mem_pc", pc, 8'h00);
    chk("rst_mem_we", dmem_we, 1'b0);
    chk("rst_mem_retire", retire, 1'b0);
    chk("rst_mem_nowrite", env_dmem[8'h11], 13'd9);
    @(posedge clk); #1;

    // BLT backwards from 0x00 wraps to 0xFF, J 0x00 returns
    set_reg(1, 13'd3);
    set_reg(2, 13'h010);
    dmem_wait = 0;
    imem[8'h00] = 13'h1656;
    run_one();
    chk("blt_wrap_pc", pc, 8'hFF);
    imem[8'hFF] = 13'h1000;
    run_one();
    chk("j_00_pc", pc, 8'h00);

    // Back-to-back run: XOR, MUL, LSL, NOP
    imem[8'h00] = 13'h0FCA;
    imem[8'h01] = 13'h06CA;
    imem[8'h02] = 13'h1F51;
    imem[8'h03] = 13'h0000;
    run = 1'b1;
    for (int i = 0; i < 3; i++) wait_retire(20);
    @(posedge clk); #1;
    run = 1'b0;
    wait_retire(20);
    @(posedge clk); #1;
    chk("xor_r7", env_rf[7], 13'h013);
    chk("mul_r3", env_rf[3], 13'h030);
    chk("lsl_r5", env_rf[5], 13'h080);
    chk("burst_pc", pc, 8'h04);
    chk("burst_idle", state, 3'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
